// File: rtl/demultiplexor_1in_3out_if.sv
// Handshake bundle for the 1-to-3 distributor: one upstream valid/ready
// channel carrying a data word plus destination code, and three downstream
// valid/ready channels (A, B, C), plus the illegal-code status outputs.
interface demultiplexor_1in_3out_if #(
    parameter int DB = 16
);
    logic [DB-1:0] Dato;
    logic [1:0]    Sel;
    logic          valid_in;
    logic          ready_in;
    logic [DB-1:0] SalidaA;
    logic [DB-1:0] SalidaB;
    logic [DB-1:0] SalidaC;
    logic          valid_A;
    logic          valid_B;
    logic          valid_C;
    logic          ready_A;
    logic          ready_B;
    logic          ready_C;
    logic          err_sel;
    logic [7:0]    drop_cnt;

    // The producer/consumer environment around the block.
    modport master (
        output Dato, Sel, valid_in, ready_A, ready_B, ready_C,
        input  ready_in, SalidaA, SalidaB, SalidaC,
        input  valid_A, valid_B, valid_C, err_sel, drop_cnt
    );

    // The distributor itself.
    modport slave (
        input  Dato, Sel, valid_in, ready_A, ready_B, ready_C,
        output ready_in, SalidaA, SalidaB, SalidaC,
        output valid_A, valid_B, valid_C, err_sel, drop_cnt
    );
endinterface

// File: rtl/demultiplexor_1in_3out.sv
// Registered 1-to-3 distributor. A single holding register carries one word
// toward the consumer chosen by its destination code (2=A, 1=B, 0=C). Code 3
// is illegal: such words are accepted, dropped, flagged and counted.
module demultiplexor_1in_3out #(
    parameter int DB = 16
) (
    input logic clk,
    input logic rst_n,
    demultiplexor_1in_3out_if.slave bus
);
    typedef enum logic {
        VACIO,
        LLENO
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DB-1:0] hold_data;
    logic [DB-1:0] hold_data_next;
    logic [1:0]    dest;
    logic [1:0]    dest_next;
    logic          err_q;
    logic          err_next;
    logic [7:0]    drop_q;
    logic [7:0]    drop_next;

    logic          dest_ready;
    logic          ready_int;
    logic          accept;
    logic          illegal;
    logic          transfer;

    // Ready of the consumer the held word is addressed to; other readies are ignored.
    always_comb begin
        dest_ready = 1'b0;
        case (dest)
            2'd2:    dest_ready = bus.ready_A;
            2'd1:    dest_ready = bus.ready_B;
            2'd0:    dest_ready = bus.ready_C;
            default: dest_ready = 1'b0;
        endcase
    end

    assign ready_int = (state == VACIO) | dest_ready;
    assign accept    = bus.valid_in & ready_int;
    assign illegal   = accept & (bus.Sel == 2'd3);
    assign transfer  = (state == LLENO) & dest_ready;

    // Next-state logic: a legal accept always (re)loads the register, so a
    // transfer and a new word in the same cycle move with no bubble.
    always_comb begin
        state_next     = state;
        hold_data_next = hold_data;
        dest_next      = dest;
        err_next       = 1'b0;
        drop_next      = drop_q;

        if (transfer) begin
            state_next = VACIO;
        end

        if (accept) begin
            if (illegal) begin
                err_next = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_next = drop_q + 8'd1;
                end
            end else begin
                state_next     = LLENO;
                hold_data_next = bus.Dato;
                dest_next      = bus.Sel;
            end
        end
    end

    // State and holding register; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= VACIO;
            hold_data <= '0;
            dest      <= 2'd0;
            err_q     <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state     <= state_next;
            hold_data <= hold_data_next;
            dest      <= dest_next;
            err_q     <= err_next;
            drop_q    <= drop_next;
        end
    end

    assign bus.ready_in = ready_int;
    assign bus.SalidaA  = hold_data;
    assign bus.SalidaB  = hold_data;
    assign bus.SalidaC  = hold_data;
    assign bus.valid_A  = (state == LLENO) && (dest == 2'd2);
    assign bus.valid_B  = (state == LLENO) && (dest == 2'd1);
    assign bus.valid_C  = (state == LLENO) && (dest == 2'd0);
    assign bus.err_sel  = err_q;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_demultiplexor_1in_3out.sv
// Testbench for the 1-to-3 distributor: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based model of the one-entry holding slot.
module tb_demultiplexor_1in_3out;
    localparam int DB = 16;

    logic clk;
    logic rst_n;

    demultiplexor_1in_3out_if #(.DB(DB)) bus ();

    demultiplexor_1in_3out #(.DB(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [DB-1:0] data;
        logic [1:0]    dest;
    } word_t;

    word_t         slot[$];
    logic [DB-1:0] last_data;
    int            drops;
    bit            err_exp;
    bit            checking;
    int            checks;
    int            errors;
    int            err_pulses;
    bit            any_valid;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DB-1:0] data, input logic [1:0] sel, input logic vin,
                                 input logic ra, input logic rb, input logic rc);
        @(posedge clk);
        #2;
        bus.Dato     = data;
        bus.Sel      = sel;
        bus.valid_in = vin;
        bus.ready_A  = ra;
        bus.ready_B  = rb;
        bus.ready_C  = rc;
    endtask

    function automatic logic port_ready(input logic [1:0] d);
        case (d)
            2'd2:    return bus.ready_A;
            2'd1:    return bus.ready_B;
            2'd0:    return bus.ready_C;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DB-1:0] salida_of(input logic [1:0] d);
        case (d)
            2'd2:    return bus.SalidaA;
            2'd1:    return bus.SalidaB;
            default: return bus.SalidaC;
        endcase
    endfunction

    function automatic logic valid_of(input logic [1:0] d);
        case (d)
            2'd2:    return bus.valid_A;
            2'd1:    return bus.valid_B;
            default: return bus.valid_C;
        endcase
    endfunction

    // Reference model: the slot is a queue of at most one word; a word leaves
    // when its consumer is ready and a new one enters whenever upstream offers
    // and the slot is empty or emptying.
    always @(posedge clk or negedge rst_n) begin
        bit leaving;
        bit taking;
        if (!rst_n) begin
            slot.delete();
            last_data = '0;
            drops     = 0;
            err_exp   = 1'b0;
        end else begin
            leaving = (slot.size() != 0) && port_ready(slot[0].dest);
            taking  = bus.valid_in && ((slot.size() == 0) || leaving);
            err_exp = 1'b0;
            if (leaving) slot.pop_front();
            if (taking) begin
                if (bus.Sel == 2'd3) begin
                    err_exp = 1'b1;
                    drops   = (drops < 255) ? drops + 1 : 255;
                end else begin
                    slot.push_back('{data: bus.Dato, dest: bus.Sel});
                    last_data = bus.Dato;
                end
            end
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        logic [1:0] d;
        bit         full;
        if (checking) begin
            full = (slot.size() != 0);
            d    = full ? slot[0].dest : 2'd3;
            checkOutput("valid_A", 32'(bus.valid_A), 32'(full && d == 2'd2));
            checkOutput("valid_B", 32'(bus.valid_B), 32'(full && d == 2'd1));
            checkOutput("valid_C", 32'(bus.valid_C), 32'(full && d == 2'd0));
            checkOutput("ready_in", 32'(bus.ready_in), 32'(!full || port_ready(d)));
            checkOutput("SalidaA", 32'(bus.SalidaA), 32'(last_data));
            checkOutput("SalidaB", 32'(bus.SalidaB), 32'(last_data));
            checkOutput("SalidaC", 32'(bus.SalidaC), 32'(last_data));
            checkOutput("err_sel", 32'(bus.err_sel), 32'(err_exp));
            checkOutput("drop_cnt", 32'(bus.drop_cnt), 32'(drops));
        end
        if (bus.err_sel === 1'b1) err_pulses++;
        if (bus.valid_A === 1'b1 || bus.valid_B === 1'b1 || bus.valid_C === 1'b1) any_valid = 1'b1;
    end

    initial begin
        logic [1:0] sels[4];
        sels[0] = 2'd2; sels[1] = 2'd1; sels[2] = 2'd0; sels[3] = 2'd2;
        checks = 0; errors = 0; checking = 1'b0; err_pulses = 0; any_valid = 1'b0;
        rst_n = 1'b0;
        bus.Dato = '0; bus.Sel = 2'd0; bus.valid_in = 1'b0;
        bus.ready_A = 1'b0; bus.ready_B = 1'b0; bus.ready_C = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checking = 1'b1;

        // Reset state.
        @(negedge clk);
        checkOutput("reset_ready_in", 32'(bus.ready_in), 32'd1);
        checkOutput("reset_valid_A", 32'(bus.valid_A), 32'd0);
        checkOutput("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);

        // Single word to A.
        applyStimulus(16'h1234, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("single_valid_A", 32'(bus.valid_A), 32'd1);
        checkOutput("single_SalidaA", 32'(bus.SalidaA), 32'h1234);
        checkOutput("single_valid_B", 32'(bus.valid_B), 32'd0);
        checkOutput("single_valid_C", 32'(bus.valid_C), 32'd0);
        applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("single_drained", 32'(bus.valid_A), 32'd0);
        checkOutput("single_ready_in", 32'(bus.ready_in), 32'd1);

        // Back-to-back stream A, B, C, A.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) applyStimulus(16'(i + 1), sels[i], 1'b1, 1'b1, 1'b1, 1'b1);
            else       applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            if (i > 0) begin
                checkOutput("stream_valid", 32'(valid_of(sels[i-1])), 32'd1);
                checkOutput("stream_data", 32'(salida_of(sels[i-1])), 32'(i));
                checkOutput("stream_ready_in", 32'(bus.ready_in), 32'd1);
            end
        end

        // Backpressure on B while a word for C waits upstream.
        applyStimulus(16'hBEEF, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput("bp_valid_B", 32'(bus.valid_B), 32'd1);
            checkOutput("bp_SalidaB", 32'(bus.SalidaB), 32'hBEEF);
            checkOutput("bp_ready_in", 32'(bus.ready_in), 32'd0);
        end
        applyStimulus(16'h0001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("bp_release_ready_in", 32'(bus.ready_in), 32'd1);
        applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("bp_next_valid_C", 32'(bus.valid_C), 32'd1);
        checkOutput("bp_next_SalidaC", 32'(bus.SalidaC), 32'h0001);
        checkOutput("bp_next_valid_B", 32'(bus.valid_B), 32'd0);
        repeat (2) applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Three illegal words.
        err_pulses = 0;
        any_valid  = 1'b0;
        repeat (3) applyStimulus(16'hDEAD, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("illegal_err_pulses", 32'(err_pulses), 32'd3);
        checkOutput("illegal_drop_cnt", 32'(bus.drop_cnt), 32'd3);
        checkOutput("illegal_no_valid", 32'(any_valid), 32'd0);

        // Saturation of the drop counter.
        repeat (300) applyStimulus(16'h5555, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("drop_cnt_saturated", 32'(bus.drop_cnt), 32'd255);

        // Asynchronous reset while a word for C is held.
        applyStimulus(16'hCAFE, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("hold_valid_C", 32'(bus.valid_C), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid_C", 32'(bus.valid_C), 32'd0);
        checkOutput("async_SalidaC", 32'(bus.SalidaC), 32'd0);
        checkOutput("async_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_ready_in", 32'(bus.ready_in), 32'd1);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] s;
            s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            applyStimulus(16'($urandom), s, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) != 0));
        end
        applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
